// File: rtl/register_pkg.sv
// Shared MODE encodings for the universal register and its next-state logic.
package register_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_INC  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_DEC  = 3'b111;

endpackage

// File: rtl/register_next_state.sv
// Combinational next-state for the universal register: one MODE per cycle,
// producing next contents, serial-out bit and carry/borrow.
module register_next_state
  import register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  q_i,
  input  logic [WIDTH-1:0]  d_i,
  input  logic              sin_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              sout_i,
  input  logic              co_i,
  output logic [WIDTH-1:0]  q_o,
  output logic              sout_o,
  output logic              co_o
);

  // Arithmetic is one bit wider so the MSB directly yields carry or borrow.
  logic [WIDTH:0] inc_sum;
  logic [WIDTH:0] dec_diff;

  assign inc_sum  = {1'b0, q_i} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_diff = {1'b0, q_i} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    q_o    = q_i;
    sout_o = sout_i;
    co_o   = co_i;
    case (mode_i)
      MODE_LOAD: q_o = d_i;
      MODE_SHL: begin
        q_o    = {q_i[WIDTH-2:0], sin_i};
        sout_o = q_i[WIDTH-1];
      end
      MODE_SHR: begin
        q_o    = {sin_i, q_i[WIDTH-1:1]};
        sout_o = q_i[0];
      end
      MODE_ROL: begin
        q_o    = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        sout_o = q_i[WIDTH-1];
      end
      MODE_ROR: begin
        q_o    = {q_i[0], q_i[WIDTH-1:1]};
        sout_o = q_i[0];
      end
      MODE_INC: begin
        q_o  = inc_sum[WIDTH-1:0];
        co_o = inc_sum[WIDTH];
      end
      MODE_DEC: begin
        q_o  = dec_diff[WIDTH-1:0];
        co_o = dec_diff[WIDTH];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/register_universal.sv
// Universal register: flops with CLR-over-EN priority and a combinational zero flag.
module register_universal
  import register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              EN,
  input  logic [MODE_W-1:0] MODE,
  input  logic [WIDTH-1:0]  D,
  input  logic              SIN,
  output logic [WIDTH-1:0]  Q,
  output logic              SOUT,
  output logic              CO,
  output logic              ZERO
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             co_q, co_d;

  register_next_state #(.WIDTH(WIDTH)) u_next (
    .q_i    (q_q),
    .d_i    (D),
    .sin_i  (SIN),
    .mode_i (MODE),
    .sout_i (sout_q),
    .co_i   (co_q),
    .q_o    (q_d),
    .sout_o (sout_d),
    .co_o   (co_d)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      q_q    <= '0;
      sout_q <= 1'b0;
      co_q   <= 1'b0;
    end else if (EN) begin
      q_q    <= q_d;
      sout_q <= sout_d;
      co_q   <= co_d;
    end
  end

  assign Q    = q_q;
  assign SOUT = sout_q;
  assign CO   = co_q;
  assign ZERO = (q_q == '0);

endmodule

// File: tb/tb_register_universal.sv
// Bench for register_universal at WIDTH 8, 2 and 32 driven by shared stimulus
// and compared against an arithmetic reference model.
module tb_register_universal;

  localparam logic [2:0] M_HOLD = 3'd0, M_LOAD = 3'd1, M_SHL = 3'd2, M_SHR = 3'd3;
  localparam logic [2:0] M_ROL  = 3'd4, M_ROR  = 3'd5, M_INC = 3'd6, M_DEC = 3'd7;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr = 1'b1;
  logic        en  = 1'b0;
  logic [2:0]  mode = M_HOLD;
  logic [63:0] d   = '0;
  logic        sin = 1'b0;

  logic [7:0]  q8;
  logic [1:0]  q2;
  logic [31:0] q32;
  logic        sout8, sout2, sout32, co8, co2, co32, zero8, zero2, zero32;

  register_universal #(.WIDTH(8)) dut8 (
    .CLK(clk), .CLR(clr), .EN(en), .MODE(mode), .D(d[7:0]), .SIN(sin),
    .Q(q8), .SOUT(sout8), .CO(co8), .ZERO(zero8));
  register_universal #(.WIDTH(2)) dut2 (
    .CLK(clk), .CLR(clr), .EN(en), .MODE(mode), .D(d[1:0]), .SIN(sin),
    .Q(q2), .SOUT(sout2), .CO(co2), .ZERO(zero2));
  register_universal #(.WIDTH(32)) dut32 (
    .CLK(clk), .CLR(clr), .EN(en), .MODE(mode), .D(d[31:0]), .SIN(sin),
    .Q(q32), .SOUT(sout32), .CO(co32), .ZERO(zero32));

  // reference model state, one slot per width
  int          ws[3] = '{8, 2, 32};
  logic [63:0] m_q[3];
  logic        m_sout[3];
  logic        m_co[3];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_q(input int i);
    case (i)
      0: obs_q = {56'd0, q8};
      1: obs_q = {62'd0, q2};
      default: obs_q = {32'd0, q32};
    endcase
  endfunction

  function automatic logic [2:0] obs_flags(input int i);
    case (i)
      0: obs_flags = {sout8, co8, zero8};
      1: obs_flags = {sout2, co2, zero2};
      default: obs_flags = {sout32, co32, zero32};
    endcase
  endfunction

  // Model: register as an unsigned number in [0, 2^w).
  task automatic model_next(input int i);
    int          w;
    logic [63:0] mask, q, top, msb, lsb;
    w    = ws[i];
    mask = (64'd1 << w) - 64'd1;
    q    = m_q[i];
    top  = 64'd1 << (w - 1);
    msb  = (q >> (w - 1)) & 64'd1;
    lsb  = q & 64'd1;
    if (clr) begin
      m_q[i] = '0; m_sout[i] = 1'b0; m_co[i] = 1'b0;
    end else if (en) begin
      case (mode)
        M_LOAD: m_q[i] = d & mask;
        M_SHL: begin m_q[i] = ((q * 2) & mask) + {63'd0, sin}; m_sout[i] = msb[0]; end
        M_SHR: begin m_q[i] = (q / 2) + (sin ? top : 64'd0); m_sout[i] = lsb[0]; end
        M_ROL: begin m_q[i] = ((q * 2) & mask) + msb; m_sout[i] = msb[0]; end
        M_ROR: begin m_q[i] = (q / 2) + (lsb * top); m_sout[i] = lsb[0]; end
        M_INC: begin m_co[i] = (q == mask); m_q[i] = (q == mask) ? 64'd0 : q + 64'd1; end
        M_DEC: begin m_co[i] = (q == 64'd0); m_q[i] = (q == 64'd0) ? mask : q - 64'd1; end
        default: ;
      endcase
    end
  endtask

  // driver: apply inputs, clock once, compare all three instances to the model
  task automatic step(input logic c, input logic e, input logic [2:0] m,
                      input logic [63:0] dv, input logic s);
    clr = c; en = e; mode = m; d = dv; sin = s;
    for (int i = 0; i < 3; i++) model_next(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("q_w%0d", ws[i]), obs_q(i), m_q[i]);
      check($sformatf("flags_w%0d", ws[i]), {61'd0, obs_flags(i)},
            {61'd0, m_sout[i], m_co[i], (m_q[i] == 64'd0)});
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin m_q[i] = '0; m_sout[i] = 1'b0; m_co[i] = 1'b0; end

    // reset, then CLR overriding an enabled LOAD
    step(1, 0, M_HOLD, 64'd0, 0);
    step(0, 1, M_LOAD, 64'hA5, 0);
    check("pre_clr_q8", {56'd0, q8}, 64'hA5);
    step(1, 1, M_LOAD, 64'h5A, 1);
    check("clr_q8", {56'd0, q8}, 64'h0);
    check("clr_flags8", {61'd0, sout8, co8, zero8}, 64'b001);

    // load then hold with EN low, then MODE HOLD
    step(0, 1, M_LOAD, 64'hAA, 0);
    repeat (3) step(0, 0, M_LOAD, 64'hF0, 1);
    step(0, 1, M_HOLD, 64'hF0, 1);
    check("hold_q8", {56'd0, q8}, 64'hAA);

    // shift serialiser
    step(0, 1, M_LOAD, 64'h81, 0);
    step(0, 1, M_SHL, 64'h0, 0);
    check("shl_q8", {56'd0, q8}, 64'h02);
    check("shl_sout8", {63'd0, sout8}, 64'd1);
    step(0, 1, M_SHR, 64'h0, 1);
    check("shr_q8", {56'd0, q8}, 64'h81);
    check("shr_sout8", {63'd0, sout8}, 64'd0);

    // rotate
    step(0, 1, M_LOAD, 64'h01, 0);
    step(0, 1, M_ROR, 64'h0, 0);
    check("ror_first_sout8", {63'd0, sout8}, 64'd1);
    repeat (7) step(0, 1, M_ROR, 64'h0, 0);
    check("ror8_q8", {56'd0, q8}, 64'h01);
    step(0, 1, M_LOAD, 64'h80, 0);
    step(0, 1, M_ROL, 64'h0, 0);
    check("rol_q8", {56'd0, q8}, 64'h01);
    check("rol_sout8", {63'd0, sout8}, 64'd1);

    // counter wrap
    step(0, 1, M_LOAD, 64'hFE, 0);
    step(0, 1, M_INC, 64'h0, 0);
    check("inc_ff_q8", {56'd0, q8}, 64'hFF);
    check("inc_ff_co8", {63'd0, co8}, 64'd0);
    step(0, 1, M_INC, 64'h0, 0);
    check("inc_wrap8", {61'd0, q8 == 8'h00, co8, zero8}, 64'b111);
    step(0, 1, M_DEC, 64'h0, 0);
    check("dec_wrap_q8", {56'd0, q8}, 64'hFF);
    check("dec_wrap_co8", {63'd0, co8}, 64'd1);

    // wider/narrower corners
    step(0, 1, M_LOAD, 64'hFFFF_FFFF, 0);
    step(0, 1, M_INC, 64'h0, 0);
    check("inc_wrap_q32", {32'd0, q32}, 64'd0);
    check("inc_wrap_co32", {63'd0, co32}, 64'd1);
    step(0, 1, M_LOAD, 64'h2, 0);
    step(0, 1, M_SHL, 64'h0, 1);
    check("shl_q2", {62'd0, q2}, 64'b01);
    check("shl_sout2", {63'd0, sout2}, 64'd1);

    // randomized mix, including occasional CLR mid-sequence and EN low
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0),
           3'($urandom_range(0, 7)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_universal.md
# register_universal

Parametrised universal register, the successor to the plain 8-bit D register with clear. Besides parallel load, it provides shift and rotate in both directions with serial in/out, increment and decrement with a carry/borrow flag, and a zero flag. It is the general-purpose storage element for datapaths that need accumulators, counters or serialisers, and it drops in wherever the fixed 8-bit register is used today.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- CLK  in  1  rising-edge clock.
- CLR  in  1  synchronous active-high reset; highest priority.
- EN  in  1  operation enable; 0 = hold everything.
- MODE  in  3  operation select (see Operation).
- D  in  WIDTH  parallel load data.
- SIN  in  1  serial input bit for SHL/SHR.
- Q  out  WIDTH  register contents (registered).
- SOUT  out  1  last bit shifted/rotated out (registered).
- CO  out  1  carry from last INC, borrow from last DEC (registered).
- ZERO  out  1  combinational, 1 when Q == 0.

## Operation
- Priority per rising CLK: CLR=1 → Q=0, SOUT=0, CO=0, regardless of EN/MODE; else EN=0 → hold Q, SOUT, CO; else apply MODE.
- MODE 000 HOLD: Q, SOUT and CO unchanged.
- MODE 001 LOAD: Q←D; SOUT and CO unchanged.
- MODE 010 SHL: Q←{Q[WIDTH-2:0],SIN}; SOUT←Q[WIDTH-1]; CO unchanged.
- MODE 011 SHR: Q←{SIN,Q[WIDTH-1:1]}; SOUT←Q[0]; CO unchanged.
- MODE 100 ROL: Q←{Q[WIDTH-2:0],Q[WIDTH-1]}; SOUT←Q[WIDTH-1]; SIN ignored.
- MODE 101 ROR: Q←{Q[0],Q[WIDTH-1:1]}; SOUT←Q[0]; SIN ignored.
- MODE 110 INC: Q←Q+1 modulo 2^WIDTH; CO←1 iff Q was all ones (wraps to 0); else CO←0. SOUT unchanged.
- MODE 111 DEC: Q←Q−1 modulo 2^WIDTH; CO←1 iff Q was 0 (wraps to all ones); else CO←0. SOUT unchanged.
- Arithmetic is unsigned and WIDTH+1 bits wide internally; the MSB of that result is CO.
- Undriven or X MODE is illegal; no recovery behaviour is defined.

## Timing
- Latency: one cycle. Inputs are sampled on a rising CLK; Q, SOUT and CO are valid after that edge.
- ZERO follows Q combinationally within the same cycle; it has no extra latency.
- Reset values: Q=0, SOUT=0, CO=0, ZERO=1.
- CLR asserted mid-sequence (for example, during a shift train) aborts the operation at that edge; the next EN=1 cycle starts from 0.
- CLR and EN=1 together: CLR wins and MODE is ignored.
- Back-to-back operations of any mix are allowed every cycle; there are no bubbles.

## Structure
- Package register_pkg holds:
  - MODE encodings as localparams: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_INC, MODE_DEC.
  - The MODE width constant (3).
- Sub-module register_next_state (combinational): computes next Q, SOUT and CO from Q, D, SIN and MODE.
- The top level holds only the flops, the CLR/EN priority and the ZERO compare.

## Test plan (WIDTH=8 unless noted)
- Reset: Q=0xA5, then CLR=1 with EN=1 and MODE=LOAD → next edge Q=0x00, SOUT=0, CO=0, ZERO=1.
- Load/hold: LOAD D=0xAA, then EN=0 with D=0xF0 for 3 cycles → Q stays 0xAA. Then HOLD with EN=1 → Q stays 0xAA.
- Shift serialiser: Q=0x81, SHL with SIN=0 → Q=0x02, SOUT=1. Then SHR with SIN=1 → Q=0x81, SOUT=0.
- Rotate: Q=0x01, eight ROR edges → Q returns to 0x01, SOUT=1 on the first edge. ROL of 0x80 → Q=0x01, SOUT=1.
- Counter wrap:
  - Q=0xFE, INC, INC → Q=0xFF with CO=0, then Q=0x00 with CO=1 and ZERO=1.
  - DEC from 0x00 → Q=0xFF, CO=1.
- Parameter sweep: repeat the shift and wrap scenarios at WIDTH=2 and WIDTH=32.
  - INC of 0xFFFFFFFF → 0 with CO=1.
  - WIDTH=2 SHL of 2'b10 with SIN=1 → 2'b01, SOUT=1.
